adder_pipe_seg: RTL and testbench

Parametrised, pipelined segmented adder/subtractor. Splits `WIDTH`-bit operands into `SEG`-bit segments, adds one segment per pipeline stage, and registers the inter-segment carry between stages. Gives full throughput (one operation per cycle) with a valid/ready handshake. It is the sequential, generalised successor to the fixed-width composed ripple adders in the regression set, and serves datapaths that need wide adds at high clock rates.

---
 rtl/adder_pipe_seg.sv | 107 ++++++++++
 tb/tb_adder_pipe_seg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe_seg.sv
// Purpose: pipelined segmented adder/subtractor; SEG bits are summed per stage and the carry is registered between stages.
// Latency: NSEG = WIDTH/SEG edges including the accepting edge; one operation per cycle while out_ready is high.
// Backpressure: a single global enable (!out_valid || out_ready) freezes every stage; in_ready equals that enable.
//
// Ports:
//   clk, rst_n          - rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready - operand handshake (in_ready never depends on in_valid)
//   a, b, cin, sub      - unsigned operands, carry-in (ignored when sub=1), subtract select
//   out_valid/out_ready - result handshake
//   sum                 - {carry-out, result}; for sub=1 the top bit set means no borrow
module adder_pipe_seg #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
);

  localparam int NSEG = WIDTH / SEG;

  generate
    if (SEG < 1 || WIDTH < SEG || (WIDTH % SEG) != 0) begin : g_bad_params
      $error("adder_pipe_seg: WIDTH must be a non-zero multiple of SEG");
    end
  endgenerate

  // Per-stage state. x_q holds the already-produced sum segments in its lower
  // part and the still-unprocessed A segments in its upper part; y_q carries the
  // conditioned B operand alongside so later stages can pick their segment.
  logic             v_q [NSEG];
  logic             c_q [NSEG];
  logic [WIDTH-1:0] x_q [NSEG];
  logic [WIDTH-1:0] y_q [NSEG];

  logic             c_d [NSEG];
  logic [WIDTH-1:0] x_d [NSEG];

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [SEG:0]     t;

  // Subtraction is A + ~B + 1, so the incoming carry is forced to one.
  assign b_eff = sub ? ~b : b;
  assign c0    = sub | cin;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = v_q[NSEG-1];
  assign sum       = {c_q[NSEG-1], x_q[NSEG-1]};

  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      x_d[k] = '0;
      c_d[k] = 1'b0;
    end
    t = '0;

    // Stage 0 works straight off the input operands.
    t = {1'b0, a[SEG-1:0]} + {1'b0, b_eff[SEG-1:0]} + {{SEG{1'b0}}, c0};
    x_d[0]          = a;
    x_d[0][SEG-1:0] = t[SEG-1:0];
    c_d[0]          = t[SEG];

    // Stage k replaces segment k of the skewed A word with its sum segment.
    for (int k = 1; k < NSEG; k++) begin
      t = {1'b0, x_q[k-1][k*SEG +: SEG]} + {1'b0, y_q[k-1][k*SEG +: SEG]}
        + {{SEG{1'b0}}, c_q[k-1]};
      x_d[k]               = x_q[k-1];
      x_d[k][k*SEG +: SEG] = t[SEG-1:0];
      c_d[k]               = t[SEG];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSEG; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        x_q[k] <= '0;
        y_q[k] <= '0;
      end
    end else if (en) begin
      // Whole pipe shifts together; empty stages move as bubbles.
      v_q[0] <= in_valid;
      c_q[0] <= c_d[0];
      x_q[0] <= x_d[0];
      y_q[0] <= b_eff;
      for (int k = 1; k < NSEG; k++) begin
        v_q[k] <= v_q[k-1];
        c_q[k] <= c_d[k];
        x_q[k] <= x_d[k];
        y_q[k] <= y_q[k-1];
      end
    end
  end

endmodule

// File: tb/tb_adder_pipe_seg.sv
// Bench for adder_pipe_seg: main 16/4 instance plus 8/8, 8/1 and 32/8 instances.
module tb_adder_pipe_seg;

  logic        clk = 1'b0;
  logic        rst_n;

  // main instance (16/4)
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready;
  logic [15:0] a, b;
  logic [16:0] sum;

  // sweep instances share their inputs
  logic        sw_in_valid, sw_cin, sw_sub, sw_out_ready;
  logic [31:0] sw_a, sw_b;
  logic [2:0]  sw_in_ready, sw_out_valid;
  logic [8:0]  sw_sum0, sw_sum1;
  logic [32:0] sw_sum2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  adder_pipe_seg #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum));

  adder_pipe_seg #(.WIDTH(8), .SEG(8)) dut_8_8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_in_ready[0]),
    .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin), .sub(sw_sub),
    .out_valid(sw_out_valid[0]), .out_ready(sw_out_ready), .sum(sw_sum0));

  adder_pipe_seg #(.WIDTH(8), .SEG(1)) dut_8_1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_in_ready[1]),
    .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin), .sub(sw_sub),
    .out_valid(sw_out_valid[1]), .out_ready(sw_out_ready), .sum(sw_sum1));

  adder_pipe_seg #(.WIDTH(32), .SEG(8)) dut_32_8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_in_ready[2]),
    .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub),
    .out_valid(sw_out_valid[2]), .out_ready(sw_out_ready), .sum(sw_sum2));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the operand values, width w.
  function automatic logic [32:0] ref_calc(input int w, input logic [31:0] aa, input logic [31:0] bb,
                                           input logic c, input logic s);
    logic [63:0] m, x, y, r;
    m = (64'd1 << w) - 64'd1;
    x = {32'd0, aa} & m;
    y = {32'd0, bb} & m;
    if (s) r = (x >= y) ? ((64'd1 << w) | (x - y)) : ((x - y) & m);
    else   r = x + y + {63'd0, c};
    return r[32:0];
  endfunction

  task automatic run_one(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic c, input logic s, input logic [16:0] exp);
    int edges;
    @(negedge clk);
    a = av; b = bv; cin = c; sub = s; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 64'(edges), 64'd4);
    check({tag, "_sum"}, 64'(sum), 64'(exp));
  endtask

  logic [16:0] q[$];
  logic [16:0] held, expv;
  logic [32:0] tmp, swv;
  logic        stall;
  int          sent, rcv, cyc, e;
  logic [31:0] ta [5];
  logic [31:0] tbv [5];
  logic        tc [5];
  logic        ts [5];
  int          wid [3];
  int          exl [3];
  int          lat [3];
  logic [32:0] val [3];
  logic [2:0]  seen;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    sw_in_valid = 1'b0; sw_out_ready = 1'b1; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_sum", 64'(sum), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_sw_in_ready", 64'(sw_in_ready), 64'd7);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // directed cases
    run_one("add_basic",   16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555);
    run_one("ripple_0",    16'hFFFF, 16'h0000, 1'b1, 1'b0, 17'h10000);
    run_one("ripple_ff",   16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1FFFF);
    run_one("sub_borrow",  16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0FFFE);
    run_one("sub_noborrow",16'h1000, 16'h0001, 1'b0, 1'b1, 17'h10FFF);
    run_one("sub_cin_ign", 16'h0003, 16'h0003, 1'b1, 1'b1, 17'h10000);

    // random streaming with backpressure
    sent = 0; rcv = 0; cyc = 0; stall = 1'b0; held = '0;
    q.delete();
    while ((sent < 200 || q.size() > 0) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      in_valid  = (sent < 200) && ($urandom_range(0, 9) < 7);
      a         = 16'($urandom);
      b         = 16'($urandom);
      cin       = 1'($urandom);
      sub       = 1'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      #1;
      check("stream_in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (stall) begin
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_sum_stable", 64'(sum), 64'(held));
      end
      if (out_valid && out_ready) begin
        rcv++;
        if (q.size() == 0) begin
          check("stream_extra_result", 64'(q.size()), 64'd1);
        end else begin
          expv = q.pop_front();
          check("stream_sum", 64'(sum), 64'(expv));
        end
      end
      if (in_valid && in_ready) begin
        tmp = ref_calc(16, {16'd0, a}, {16'd0, b}, cin, sub);
        q.push_back(tmp[16:0]);
        sent++;
      end
      stall = out_valid && !out_ready;
      held  = sum;
    end
    check("stream_within_budget", 64'(cyc < 5000), 64'd1);
    check("stream_received", 64'(rcv), 64'd200);
    check("stream_leftover", 64'(q.size()), 64'd0);

    // reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      a = 16'($urandom); b = 16'($urandom); cin = 1'b1; sub = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_sum", 64'(sum), 64'd0);
    check("midreset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_reset_no_stale", 64'(out_valid), 64'd0);
    end
    check("post_reset_in_ready", 64'(in_ready), 64'd1);

    // parameter sweep on corner operands
    ta[0] = 32'h0;        tbv[0] = 32'h0;        tc[0] = 1'b0; ts[0] = 1'b0;
    ta[1] = 32'hFFFFFFFF; tbv[1] = 32'hFFFFFFFF; tc[1] = 1'b1; ts[1] = 1'b0;
    ta[2] = 32'h1;        tbv[2] = 32'hFFFFFFFF; tc[2] = 1'b0; ts[2] = 1'b1;
    ta[3] = 32'hFFFFFFFF; tbv[3] = 32'h1;        tc[3] = 1'b0; ts[3] = 1'b1;
    ta[4] = 32'h1;        tbv[4] = 32'hFFFFFFFF; tc[4] = 1'b1; ts[4] = 1'b0;
    wid[0] = 8; wid[1] = 8; wid[2] = 32;
    exl[0] = 1; exl[1] = 8; exl[2] = 4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sw_a = ta[i]; sw_b = tbv[i]; sw_cin = tc[i]; sw_sub = ts[i];
      sw_in_valid = 1'b1; sw_out_ready = 1'b1;
      @(posedge clk);
      e = 1;
      @(negedge clk);
      sw_in_valid = 1'b0;
      seen = '0;
      for (int j = 0; j < 3; j++) begin
        lat[j] = 0;
        val[j] = '0;
      end
      while (e <= 12) begin
        for (int j = 0; j < 3; j++) begin
          swv = (j == 0) ? 33'(sw_sum0) : (j == 1) ? 33'(sw_sum1) : sw_sum2;
          if (sw_out_valid[j] && !seen[j]) begin
            seen[j] = 1'b1;
            lat[j]  = e;
            val[j]  = swv;
          end
        end
        @(posedge clk);
        e++;
        @(negedge clk);
      end
      for (int j = 0; j < 3; j++) begin
        check($sformatf("sweep_w%0d_l%0d_op%0d_latency", wid[j], exl[j], i), 64'(lat[j]), 64'(exl[j]));
        check($sformatf("sweep_w%0d_l%0d_op%0d_sum", wid[j], exl[j], i), 64'(val[j]),
              64'(ref_calc(wid[j], ta[i], tbv[i], tc[i], ts[i])));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
